// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus owner arbiter: source count, select width,
// arbiter state encoding and the hold-counter width helper.
package bus_arb_pkg;

   localparam int unsigned NUM_SRC = 8;
   localparam int unsigned SEL_W   = 3;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StTurn
   } arb_state_e;

   // Hold counter needs to reach MAX_HOLD-1; keep at least one bit so that
   // MAX_HOLD = 0 (unlimited) still yields a legal vector.
   function automatic int unsigned hold_cnt_w(input int unsigned max_hold);
      int unsigned w;
      w = $clog2(max_hold + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: the first set request at or after last+1,
// wrapping around the eight sources.
module rr_pick8
   import bus_arb_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   last,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);

   logic [SEL_W-1:0] cand;

   // Scan last+1 .. last+8 (mod 8); the first hit wins.
   always_comb begin
      found = 1'b0;
      idx   = last;
      cand  = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         cand = last + SEL_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for a shared 8:1 bus mux. Drives the mux select
// and active-low enable, floats the bus for TURN_CYCLES between owners and
// bounds contended tenures to MAX_HOLD cycles.
module bus_owner_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD    = 16,
   parameter int unsigned TURN_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] req,
   output logic [NUM_SRC-1:0] grant,
   output logic [SEL_W-1:0]   select,
   output logic               enable,
   output logic               busy
);

   localparam int unsigned HOLD_W = hold_cnt_w(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_MAX =
      HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic [SEL_W-1:0]   select_q, select_d;
   logic               enable_q, enable_d;
   logic               busy_q, busy_d;
   logic [SEL_W-1:0]   last_q, last_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [3:0]         turn_q, turn_d;

   logic               pick_found;
   logic [SEL_W-1:0]   pick_idx;
   logic               owner_req;
   logic               others_wait;

   rr_pick8 u_pick (
      .req   (req),
      .last  (last_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign owner_req   = req[select_q];
   assign others_wait = |(req & ~grant_q);

   // Next-state and next-output logic; all bus controls move on the same edge.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      select_d = select_q;
      enable_d = enable_q;
      busy_d   = busy_q;
      last_d   = last_q;
      hold_d   = hold_q;
      turn_d   = turn_q;

      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               state_d           = StGrant;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               select_d          = pick_idx;
               last_d            = pick_idx;
               enable_d          = 1'b0;
               busy_d            = 1'b1;
               hold_d            = '0;
            end
         end
         StGrant: begin
            if (!owner_req ||
                ((MAX_HOLD != 0) && (hold_q == HOLD_MAX) && others_wait)) begin
               // Release (voluntary or forced): float the bus.
               state_d  = StTurn;
               grant_d  = '0;
               enable_d = 1'b1;
               turn_d   = '0;
            end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
               hold_d = hold_q + 1'b1;
            end
         end
         StTurn: begin
            if (turn_q == TURN_LAST) begin
               turn_d = '0;
               if (pick_found) begin
                  state_d           = StGrant;
                  grant_d           = '0;
                  grant_d[pick_idx] = 1'b1;
                  select_d          = pick_idx;
                  last_d            = pick_idx;
                  enable_d          = 1'b0;
                  hold_d            = '0;
               end else begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end
            end else begin
               turn_d = turn_q + 1'b1;
            end
         end
         default: begin
            state_d  = StIdle;
            grant_d  = '0;
            enable_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs; reset floats the bus at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         select_q <= '0;
         enable_q <= 1'b1;
         busy_q   <= 1'b0;
         last_q   <= SEL_W'(NUM_SRC - 1);
         hold_q   <= '0;
         turn_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         select_q <= select_d;
         enable_q <= enable_d;
         busy_q   <= busy_d;
         last_q   <= last_d;
         hold_q   <= hold_d;
         turn_q   <= turn_d;
      end
   end

   assign grant  = grant_q;
   assign select = select_q;
   assign enable = enable_q;
   assign busy   = busy_q;

endmodule
